id_ex_operand_stage: RTL and testbench



---
 rtl/id_ex_operand_stage.sv | 179 +++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID->EX operand-fetch stage: x0 forcing, writeback bypass, load-use tracking and a valid/ready output register.
// Define OPFETCH_WB_BYPASS_EN to enable the same-cycle writeback bypass; otherwise writeback matches stall one cycle.
module id_ex_operand_stage #(
    parameter int CTRL_W   = 16,
    parameter int LOAD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_we,
    input  logic              in_is_load,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [4:0]        rf_a1,
    output logic [4:0]        rf_a2,
    input  logic [31:0]       rf_rd1,
    input  logic [31:0]       rf_rd2,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_imm,
    output logic [31:0]       out_rs1_val,
    output logic [31:0]       out_rs2_val,
    output logic [4:0]        out_rd,
    output logic              out_rd_we,
    output logic              out_is_load,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_pc_q, out_pc_d;
    logic [31:0]       out_imm_q, out_imm_d;
    logic [31:0]       out_rs1_val_q, out_rs1_val_d;
    logic [31:0]       out_rs2_val_q, out_rs2_val_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              out_rd_we_q, out_rd_we_d;
    logic              out_is_load_q, out_is_load_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;

    logic [LOAD_LAT-1:0] trk_valid_q, trk_valid_d;
    logic [4:0]          trk_rd_q [LOAD_LAT];
    logic [4:0]          trk_rd_d [LOAD_LAT];

    logic        hazard;
    logic [4:0]  src_rs;
    logic [31:0] rs1_val, rs2_val;
    logic        accept, handoff, insert;

    assign rf_a1 = in_rs1;
    assign rf_a2 = in_rs2;

`ifdef OPFETCH_WB_BYPASS_EN
    always_comb begin
        rs1_val = rf_rd1;
        rs2_val = rf_rd2;
        if (wb_we && wb_rd == in_rs1) rs1_val = wb_data;
        if (wb_we && wb_rd == in_rs2) rs2_val = wb_data;
        if (in_rs1 == 5'd0) rs1_val = 32'd0;
        if (in_rs2 == 5'd0) rs2_val = 32'd0;
    end
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;

    always_comb begin
        rs1_val = rf_rd1;
        rs2_val = rf_rd2;
        if (in_rs1 == 5'd0) rs1_val = 32'd0;
        if (in_rs2 == 5'd0) rs2_val = 32'd0;
    end
`endif

    // A source is blocked by a held load, any in-flight tracked load, or (without bypass) a same-cycle writeback.
    always_comb begin
        hazard = 1'b0;
        src_rs = in_rs1;
        for (int s = 0; s < 2; s++) begin
            src_rs = (s == 0) ? in_rs1 : in_rs2;
            if (in_valid && src_rs != 5'd0) begin
                if (out_valid_q && out_is_load_q && out_rd_we_q && out_rd_q == src_rs) hazard = 1'b1;
                for (int i = 0; i < LOAD_LAT; i++) begin
                    if (trk_valid_q[i] && trk_rd_q[i] == src_rs) hazard = 1'b1;
                end
`ifndef OPFETCH_WB_BYPASS_EN
                if (wb_we && wb_rd == src_rs) hazard = 1'b1;
`endif
            end
        end
    end

    assign in_ready = !rst && !flush && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid_q && out_ready;
    assign insert   = handoff && out_is_load_q && out_rd_we_q && (out_rd_q != 5'd0);

    always_comb begin
        trk_valid_d[0] = insert;
        trk_rd_d[0]    = insert ? out_rd_q : 5'd0;
        for (int i = 1; i < LOAD_LAT; i++) begin
            trk_valid_d[i] = trk_valid_q[i-1];
            trk_rd_d[i]    = trk_rd_q[i-1];
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_imm_d     = out_imm_q;
        out_rs1_val_d = out_rs1_val_q;
        out_rs2_val_d = out_rs2_val_q;
        out_rd_d      = out_rd_q;
        out_rd_we_d   = out_rd_we_q;
        out_is_load_d = out_is_load_q;
        out_ctrl_d    = out_ctrl_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            out_pc_d      = in_pc;
            out_imm_d     = in_imm;
            out_rs1_val_d = rs1_val;
            out_rs2_val_d = rs2_val;
            out_rd_d      = in_rd;
            out_rd_we_d   = in_rd_we;
            out_is_load_d = in_is_load;
            out_ctrl_d    = in_ctrl;
        end else if (handoff) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_imm_q     <= '0;
            out_rs1_val_q <= '0;
            out_rs2_val_q <= '0;
            out_rd_q      <= '0;
            out_rd_we_q   <= 1'b0;
            out_is_load_q <= 1'b0;
            out_ctrl_q    <= '0;
            trk_valid_q   <= '0;
            for (int i = 0; i < LOAD_LAT; i++) trk_rd_q[i] <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_imm_q     <= out_imm_d;
            out_rs1_val_q <= out_rs1_val_d;
            out_rs2_val_q <= out_rs2_val_d;
            out_rd_q      <= out_rd_d;
            out_rd_we_q   <= out_rd_we_d;
            out_is_load_q <= out_is_load_d;
            out_ctrl_q    <= out_ctrl_d;
            trk_valid_q   <= trk_valid_d;
            for (int i = 0; i < LOAD_LAT; i++) trk_rd_q[i] <= trk_rd_d[i];
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_imm     = out_imm_q;
    assign out_rs1_val = out_rs1_val_q;
    assign out_rs2_val = out_rs2_val_q;
    assign out_rd      = out_rd_q;
    assign out_rd_we   = out_rd_we_q;
    assign out_is_load = out_is_load_q;
    assign out_ctrl    = out_ctrl_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus random traffic against a cycle-count based reference model.
// Honours OPFETCH_WB_BYPASS_EN the same way the design does.
module tb_id_ex_operand_stage;

    localparam int CTRL_W   = 16;
    localparam int LOAD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready;
    logic [4:0]        in_rs1, in_rs2, in_rd;
    logic              in_rd_we, in_is_load;
    logic [31:0]       in_pc, in_imm;
    logic [CTRL_W-1:0] in_ctrl;
    logic [4:0]        rf_a1, rf_a2;
    logic [31:0]       rf_rd1, rf_rd2;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              flush;
    logic              out_valid, out_ready;
    logic [31:0]       out_pc, out_imm, out_rs1_val, out_rs2_val;
    logic [4:0]        out_rd;
    logic              out_rd_we, out_is_load;
    logic [CTRL_W-1:0] out_ctrl;

    logic [31:0] regs [32];
    assign rf_rd1 = regs[rf_a1];
    assign rf_rd2 = regs[rf_a2];

    id_ex_operand_stage #(.CTRL_W(CTRL_W), .LOAD_LAT(LOAD_LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rd_we(in_rd_we), .in_is_load(in_is_load),
        .in_pc(in_pc), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_load(out_is_load),
        .out_ctrl(out_ctrl)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [31:0]       imm;
        logic [31:0]       rs1v;
        logic [31:0]       rs2v;
        logic [4:0]        rd;
        logic              rd_we;
        logic              is_load;
        logic [CTRL_W-1:0] ctrl;
    } held_t;

    held_t      m;
    int         cycle;
    int         ld_until[$];
    logic [4:0] ld_rd[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       last_ready;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // A register is unavailable if a held load targets it, or a load handed off within the last LOAD_LAT cycles does.
    function automatic bit blocked(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        if (m.valid && m.is_load && m.rd_we && m.rd == rs) return 1'b1;
        foreach (ld_rd[i]) if (ld_rd[i] == rs && cycle <= ld_until[i]) return 1'b1;
`ifndef OPFETCH_WB_BYPASS_EN
        if (wb_we && wb_rd == rs) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] resolve(input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
`ifdef OPFETCH_WB_BYPASS_EN
        if (wb_we && wb_rd == rs) return wb_data;
`endif
        return regs[rs];
    endfunction

    // One clock cycle: check outputs against the model mid-cycle, then advance model and register file past the edge.
    task automatic applyStimulus();
        held_t       nxt;
        bit          exp_ready;
        bit          do_wr;
        logic [4:0]  wr_rd;
        logic [31:0] wr_data;
        @(negedge clk);
        #1;
        while (ld_until.size() > 0 && ld_until[0] < cycle) begin
            void'(ld_until.pop_front());
            void'(ld_rd.pop_front());
        end
        exp_ready = !rst && !flush && !(in_valid && (blocked(in_rs1) || blocked(in_rs2)))
                    && (!m.valid || out_ready);
        checkOutput("in_ready",    64'(in_ready),    64'(exp_ready));
        checkOutput("rf_a1",       64'(rf_a1),       64'(in_rs1));
        checkOutput("rf_a2",       64'(rf_a2),       64'(in_rs2));
        checkOutput("out_valid",   64'(out_valid),   64'(m.valid));
        checkOutput("out_pc",      64'(out_pc),      64'(m.pc));
        checkOutput("out_imm",     64'(out_imm),     64'(m.imm));
        checkOutput("out_rs1_val", 64'(out_rs1_val), 64'(m.rs1v));
        checkOutput("out_rs2_val", 64'(out_rs2_val), 64'(m.rs2v));
        checkOutput("out_rd",      64'(out_rd),      64'(m.rd));
        checkOutput("out_rd_we",   64'(out_rd_we),   64'(m.rd_we));
        checkOutput("out_is_load", 64'(out_is_load), 64'(m.is_load));
        checkOutput("out_ctrl",    64'(out_ctrl),    64'(m.ctrl));
        last_ready = in_ready;
        nxt = m;
        if (rst) begin
            nxt = '0;
            ld_until.delete();
            ld_rd.delete();
        end else begin
            if (m.valid && out_ready && m.is_load && m.rd_we && m.rd != 5'd0) begin
                ld_until.push_back(cycle + LOAD_LAT);
                ld_rd.push_back(m.rd);
            end
            if (flush) begin
                nxt.valid = 1'b0;
            end else if (in_valid && exp_ready) begin
                nxt.valid   = 1'b1;
                nxt.pc      = in_pc;
                nxt.imm     = in_imm;
                nxt.rs1v    = resolve(in_rs1);
                nxt.rs2v    = resolve(in_rs2);
                nxt.rd      = in_rd;
                nxt.rd_we   = in_rd_we;
                nxt.is_load = in_is_load;
                nxt.ctrl    = in_ctrl;
            end else if (out_ready) begin
                nxt.valid = 1'b0;
            end
        end
        do_wr   = wb_we && wb_rd != 5'd0;
        wr_rd   = wb_rd;
        wr_data = wb_data;
        @(posedge clk);
        #1;
        m = nxt;
        if (do_wr) regs[wr_rd] = wr_data;
        cycle++;
    endtask

    task automatic setIdle();
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    endtask

    task automatic setInstr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic rd_we, input logic is_load);
        in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rd_we = rd_we; in_is_load = is_load;
        in_pc = $urandom; in_imm = $urandom; in_ctrl = CTRL_W'($urandom);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        regs[0] = 32'hDEADBEEF;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        setIdle();
        setInstr(5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m = '0;
        cycle = 0;

        // Reset holds everything idle and refuses input, then x0 reads as zero despite register-file garbage.
        applyStimulus();
        checkOutput("rst_in_ready", 64'(last_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        applyStimulus();
        checkOutput("x0_accept", 64'(last_ready), 64'd1);
        checkOutput("x0_latency", 64'(out_valid), 64'd1);
        checkOutput("x0_forced", 64'(out_rs1_val), 64'd0);

        // Same-cycle writeback to r5 while the register file still holds the old value.
        setIdle();
        regs[5] = 32'd0;
        setInstr(5'd0, 5'd5, 5'd2, 1'b1, 1'b0);
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        applyStimulus();
`ifdef OPFETCH_WB_BYPASS_EN
        checkOutput("byp_accept", 64'(last_ready), 64'd1);
        checkOutput("byp_rs2", 64'(out_rs2_val), 64'h1234);
`else
        checkOutput("nobyp_stall", 64'(last_ready), 64'd0);
        wb_we = 1'b0;
        applyStimulus();
        checkOutput("nobyp_accept", 64'(last_ready), 64'd1);
        checkOutput("nobyp_rs2", 64'(out_rs2_val), 64'h1234);
`endif

        // Load to r7 followed by a dependent instruction.
        setIdle();
        setInstr(5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
        applyStimulus();
        setInstr(5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("lu_held_stall", 64'(last_ready), 64'd0);
        for (int k = 1; k <= LOAD_LAT; k++) begin
            applyStimulus();
            checkOutput("lu_trk_stall", 64'(last_ready), 64'd0);
        end
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hCAFE;
        applyStimulus();
`ifdef OPFETCH_WB_BYPASS_EN
        checkOutput("lu_accept", 64'(last_ready), 64'd1);
        checkOutput("lu_rs1", 64'(out_rs1_val), 64'hCAFE);
`else
        checkOutput("lu_wb_stall", 64'(last_ready), 64'd0);
        wb_we = 1'b0;
        applyStimulus();
        checkOutput("lu_accept", 64'(last_ready), 64'd1);
        checkOutput("lu_rs1", 64'(out_rs1_val), 64'hCAFE);
`endif

        // Downstream backpressure for four cycles, then release.
        setIdle();
        setInstr(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        in_pc = 32'h100;
        applyStimulus();
        out_ready = 1'b0;
        setInstr(5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
        in_pc = 32'h200;
        repeat (4) begin
            applyStimulus();
            checkOutput("bp_in_ready", 64'(last_ready), 64'd0);
            checkOutput("bp_out_pc", 64'(out_pc), 64'h100);
        end
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("bp_release", 64'(last_ready), 64'd1);
        checkOutput("bp_next_pc", 64'(out_pc), 64'h200);

        // Flush of a stalled instruction must not clear the in-flight load tracker.
        setIdle();
        setInstr(5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
        applyStimulus();
        setInstr(5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("fl_pipe_accept", 64'(last_ready), 64'd1);
        out_ready = 1'b0; flush = 1'b1;
        setInstr(5'd7, 5'd0, 5'd10, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("fl_in_ready", 64'(last_ready), 64'd0);
        checkOutput("fl_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1; flush = 1'b0;
        applyStimulus();
        checkOutput("fl_trk_stall", 64'(last_ready), 64'd0);
        applyStimulus();
        checkOutput("fl_trk_release", 64'(last_ready), 64'd1);

        // A load to x0 creates no dependency.
        setIdle();
        setInstr(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        applyStimulus();
        setInstr(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("ld_x0_accept", 64'(last_ready), 64'd1);
        checkOutput("ld_x0_rs1", 64'(out_rs1_val), 64'd0);

        for (int i = 0; i < 800; i++) begin
            rst        = ($urandom_range(0, 99) < 2);
            flush      = ($urandom_range(0, 99) < 6);
            out_ready  = ($urandom_range(0, 99) < 70);
            in_valid   = ($urandom_range(0, 99) < 80);
            in_rs1     = 5'($urandom_range(0, 7));
            in_rs2     = 5'($urandom_range(0, 7));
            in_rd      = 5'($urandom_range(0, 7));
            in_rd_we   = ($urandom_range(0, 99) < 80);
            in_is_load = ($urandom_range(0, 99) < 30);
            in_pc      = $urandom;
            in_imm     = $urandom;
            in_ctrl    = CTRL_W'($urandom);
            wb_we      = ($urandom_range(0, 99) < 40);
            wb_rd      = 5'($urandom_range(0, 7));
            wb_data    = $urandom;
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
